// File: rtl/id_remap_table.sv
// ID-to-slot remap table: in-flight requests with the same ID share one ref-counted slot.
// Optional macro ID_REMAP_TABLE_ERR_EN adds a sticky protocol-error flag and sim assertions.
module id_remap_table #(
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNT_WIDTH       = 4,
  localparam int IDX_W          = $clog2(MAX_OUTSTANDING)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  input  logic [ID_WIDTH-1:0] in_id,
  output logic                grant_valid,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                grant_hit,
  input  logic                free_valid,
  input  logic [IDX_W-1:0]    free_idx,
  input  logic [IDX_W-1:0]    lookup_idx,
  output logic [ID_WIDTH-1:0] lookup_id,
  output logic [IDX_W:0]      used_slots,
  output logic                full,
  output logic                err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [MAX_OUTSTANDING-1:0] alloc_q, alloc_d;
  logic [ID_WIDTH-1:0]        id_q  [MAX_OUTSTANDING];
  logic [ID_WIDTH-1:0]        id_d  [MAX_OUTSTANDING];
  logic [CNT_WIDTH-1:0]       cnt_q [MAX_OUTSTANDING];
  logic [CNT_WIDTH-1:0]       cnt_d [MAX_OUTSTANDING];
  logic [IDX_W:0]             used_q, used_d;
  logic                       grant_valid_q, grant_valid_d;
  logic                       grant_hit_q, grant_hit_d;
  logic [IDX_W-1:0]           grant_idx_q, grant_idx_d;

  logic             hit, free_found, fire, free_in_range, free_ok, rel;
  logic [IDX_W-1:0] hit_idx, free_first, sel_idx;

  // Search works on registered state only, so a slot freed this cycle is not reusable yet.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_first = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (alloc_q[i] && id_q[i] == in_id) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!alloc_q[i] && !free_found) begin
        free_found = 1'b1;
        free_first = IDX_W'(i);
      end
    end
  end

  assign full          = &alloc_q;
  assign alloc_ready   = hit ? (cnt_q[hit_idx] != CNT_MAX) : !full;
  assign fire          = alloc_valid && alloc_ready;
  assign sel_idx       = hit ? hit_idx : free_first;
  assign free_in_range = int'(free_idx) < MAX_OUTSTANDING;
  assign free_ok       = free_valid && free_in_range && alloc_q[free_idx] && (cnt_q[free_idx] != '0);
  assign lookup_id     = (int'(lookup_idx) < MAX_OUTSTANDING) ? id_q[lookup_idx] : '0;

  always_comb begin
    alloc_d = alloc_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    rel     = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (fire && sel_idx == IDX_W'(i) && !hit) begin
        alloc_d[i] = 1'b1;
        id_d[i]    = in_id;
        cnt_d[i]   = CNT_WIDTH'(1);
      end else if (fire && sel_idx == IDX_W'(i) && !(free_ok && free_idx == IDX_W'(i))) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end else if (free_ok && free_idx == IDX_W'(i) && !(fire && sel_idx == IDX_W'(i))) begin
        cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
        if (cnt_q[i] == CNT_WIDTH'(1)) begin
          alloc_d[i] = 1'b0;
          rel        = 1'b1;
        end
      end
    end
    used_d = used_q;
    if (fire && !hit) used_d = used_d + (IDX_W+1)'(1);
    if (rel)          used_d = used_d - (IDX_W+1)'(1);
    grant_valid_d = fire;
    grant_idx_d   = fire ? sel_idx : grant_idx_q;
    grant_hit_d   = fire ? hit : grant_hit_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q       <= '0;
      used_q        <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      grant_hit_q   <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        id_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      alloc_q       <= alloc_d;
      id_q          <= id_d;
      cnt_q         <= cnt_d;
      used_q        <= used_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      grant_hit_q   <= grant_hit_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign grant_hit   = grant_hit_q;
  assign used_slots  = used_q;

`ifdef ID_REMAP_TABLE_ERR_EN
  logic                err_q, err_d, stall_q;
  logic [ID_WIDTH-1:0] in_id_q;
  logic                bad_free, bad_stall;

  assign bad_free  = free_valid && (!free_in_range || !alloc_q[free_idx]);
  assign bad_stall = stall_q && (!alloc_valid || in_id != in_id_q);
  assign err_d     = err_q || bad_free || bad_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= 1'b0;
      stall_q <= 1'b0;
      in_id_q <= '0;
    end else begin
      err_q   <= err_d;
      stall_q <= alloc_valid && !alloc_ready;
      in_id_q <= in_id;
    end
  end

  assign err = err_q;

`ifndef SYNTHESIS
  a_free_unalloc: assert property (@(posedge clk) disable iff (rst) !bad_free);
  a_stall_hold:   assert property (@(posedge clk) disable iff (rst) !bad_stall);
`endif
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_id_remap_table.sv
// Bench for id_remap_table: slot-table reference model checked every cycle plus directed literal checks.
module tb_id_remap_table;
  localparam int IW = 5;
  localparam int N  = 16;
  localparam int CW = 4;
  localparam int XW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alloc_valid = 1'b0;
  logic          alloc_ready;
  logic [IW-1:0] in_id = '0;
  logic          grant_valid;
  logic [XW-1:0] grant_idx;
  logic          grant_hit;
  logic          free_valid = 1'b0;
  logic [XW-1:0] free_idx = '0;
  logic [XW-1:0] lookup_idx = '0;
  logic [IW-1:0] lookup_id;
  logic [XW:0]   used_slots;
  logic          full;
  logic          err;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  id_remap_table #(.ID_WIDTH(IW), .MAX_OUTSTANDING(N), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .in_id(in_id), .grant_valid(grant_valid), .grant_idx(grant_idx), .grant_hit(grant_hit),
    .free_valid(free_valid), .free_idx(free_idx), .lookup_idx(lookup_idx),
    .lookup_id(lookup_id), .used_slots(used_slots), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what each slot holds, how many requests it carries.
  bit m_alloc [N];
  int m_id    [N];
  int m_cnt   [N];
  bit e_gv, e_gh, e_err, m_stall;
  int e_gi, m_prev_id;

  initial begin
    int  h, ff, na, fi, ofc;
    bit  e_rdy, e_full, fire, ofa;
    forever begin
      @(negedge clk);
      h = -1; ff = -1; na = 0;
      for (int i = 0; i < N; i++) begin
        if (m_alloc[i]) na++;
        if (m_alloc[i] && m_id[i] == int'(in_id)) h = i;
      end
      for (int i = N - 1; i >= 0; i--) if (!m_alloc[i]) ff = i;
      e_full = (na == N);
      e_rdy  = (h >= 0) ? (m_cnt[h] < CMAX) : !e_full;
      if (started) begin
        chk("alloc_ready", alloc_ready, e_rdy);
        chk("full", full, e_full);
        chk("lookup_id", lookup_id, m_id[lookup_idx]);
        chk("used_slots", used_slots, na);
        chk("grant_valid", grant_valid, e_gv);
        if (e_gv) begin
          chk("grant_idx", grant_idx, e_gi);
          chk("grant_hit", grant_hit, e_gh);
        end
        chk("err", err, e_err);
      end
      if (rst) begin
        for (int i = 0; i < N; i++) begin
          m_alloc[i] = 1'b0; m_id[i] = 0; m_cnt[i] = 0;
        end
        e_gv = 0; e_gi = 0; e_gh = 0; e_err = 0; m_stall = 0; m_prev_id = 0;
        started = 1'b1;
      end else begin
        fire = alloc_valid && e_rdy;
        fi   = int'(free_idx);
        ofa  = m_alloc[fi];
        ofc  = m_cnt[fi];
`ifdef ID_REMAP_TABLE_ERR_EN
        if ((free_valid && !ofa) || (m_stall && (!alloc_valid || int'(in_id) != m_prev_id)))
          e_err = 1'b1;
        m_stall   = alloc_valid && !e_rdy;
        m_prev_id = int'(in_id);
`endif
        e_gv = fire;
        if (fire) begin
          if (h >= 0) begin
            m_cnt[h]++;
            e_gi = h; e_gh = 1'b1;
          end else begin
            m_alloc[ff] = 1'b1; m_id[ff] = int'(in_id); m_cnt[ff] = 1;
            e_gi = ff; e_gh = 1'b0;
          end
        end
        if (free_valid && ofa && ofc > 0) begin
          m_cnt[fi]--;
          if (m_cnt[fi] == 0) m_alloc[fi] = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc_one(input int id);
    bit done = 1'b0;
    alloc_valid = 1'b1;
    in_id = IW'(id);
    for (int k = 0; k < 40 && !done; k++) begin
      #1;
      if (alloc_ready) done = 1'b1;
      step();
    end
    alloc_valid = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL alloc_timeout: id %0d never accepted", id);
    end
  endtask

  task automatic free_one(input int idx);
    free_valid = 1'b1;
    free_idx = XW'(idx);
    step();
    free_valid = 1'b0;
  endtask

  task automatic fill_all();
    for (int v = 0; v < N; v++) alloc_one(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) step();
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_grant_hit", grant_hit, 0);
    chk("rst_used", used_slots, 0);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    alloc_one(3);
    chk("first_gv", grant_valid, 1);
    chk("first_gi", grant_idx, 0);
    chk("first_gh", grant_hit, 0);
    chk("first_used", used_slots, 1);
    step();
    chk("grant_pulse", grant_valid, 0);

    alloc_one(3);
    alloc_one(3);
    chk("reuse_gi", grant_idx, 0);
    chk("reuse_gh", grant_hit, 1);
    alloc_one(5);
    chk("id5_gi", grant_idx, 1);
    chk("id5_gh", grant_hit, 0);
    lookup_idx = 4'd1;
    #1;
    chk("lookup1", lookup_id, 5);

    for (int v = 0; v < N; v++) if (v != 3 && v != 5) alloc_one(v);
    chk("fill_full", full, 1);
    chk("fill_used", used_slots, 16);
    lookup_idx = 4'd7;
    #1;
    chk("lookup7", lookup_id, 7);
    alloc_valid = 1'b1;
    in_id = 5'd20;
    step();
    step();
    chk("full_stall_ready", alloc_ready, 0);
    chk("full_stall_gv", grant_valid, 0);
    free_one(7);
    chk("freed_full", full, 0);
    chk("freed_gv", grant_valid, 0);
    step();
    alloc_valid = 1'b0;
    chk("refill_gv", grant_valid, 1);
    chk("refill_gi", grant_idx, 7);
    chk("refill_gh", grant_hit, 0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < CMAX; k++) alloc_one(2);
    chk("sat_last_gh", grant_hit, 1);
    alloc_valid = 1'b1;
    in_id = 5'd2;
    step();
    step();
    chk("sat_ready", alloc_ready, 0);
    chk("sat_gv", grant_valid, 0);
    free_one(0);
    chk("sat_free_gv", grant_valid, 0);
    step();
    alloc_valid = 1'b0;
    chk("sat_fire_gv", grant_valid, 1);
    chk("sat_fire_gh", grant_hit, 1);
    chk("sat_fire_gi", grant_idx, 0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    alloc_one(9);
    chk("same_pre_used", used_slots, 1);
    alloc_valid = 1'b1; in_id = 5'd9;
    free_valid = 1'b1;  free_idx = 4'd0;
    step();
    alloc_valid = 1'b0; free_valid = 1'b0;
    chk("same_gv", grant_valid, 1);
    chk("same_gh", grant_hit, 1);
    chk("same_used", used_slots, 1);
    chk("same_full", full, 0);
    lookup_idx = 4'd0;
    #1;
    chk("same_lookup", lookup_id, 9);
    free_one(0);
    chk("same_drain_used", used_slots, 0);
    free_one(0);
    chk("underflow_used", used_slots, 0);
    free_one(4);
    step();
    chk("unalloc_used", used_slots, 0);
`ifdef ID_REMAP_TABLE_ERR_EN
    chk("err_set", err, 1);
`else
    chk("err_off", err, 0);
`endif
    repeat (3) step();

    rst = 1'b1;
    step();
    rst = 1'b0;
    fill_all();
    alloc_valid = 1'b1;
    in_id = 5'd20;
    step();
    step();
    chk("rst_stall_ready", alloc_ready, 0);
    rst = 1'b1;
    step();
    chk("midrst_gv", grant_valid, 0);
    chk("midrst_used", used_slots, 0);
    chk("midrst_full", full, 0);
    chk("midrst_err", err, 0);
    in_id = 5'd3;
    step();
    rst = 1'b0;
    alloc_valid = 1'b0;
    chk("rst_fire_gv", grant_valid, 0);
    chk("rst_fire_used", used_slots, 0);
    step();
    chk("post_rst_gv", grant_valid, 0);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/id_remap_table.md
Name: id_remap_table

Overview:
- Parametrised ID-to-slot remapping table for the ROB front end.
- Maps each incoming original AXI ID to a slot index in [0..MAX_OUTSTANDING-1].
- All in-flight requests with the same ID share one slot, which preserves same-ID ordering.
- Per-slot reference counts track in-flight transactions; a valid/ready allocate port, a free port, and a combinational lookup port (restores the original ID on responses) surround the table.

Parameters:
- ID_WIDTH, 4, width of original AXI ID.
- MAX_OUTSTANDING, 16, number of slots (N); must be >= 2.
- CNT_WIDTH, 4, width of per-slot outstanding counter; max per-slot count = 2^CNT_WIDTH-1.
- Derived (localparam, not overridable): IDX_W = $clog2(MAX_OUTSTANDING).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- alloc_valid  in  1  allocation request.
- alloc_ready  out  1  table can accept in_id this cycle.
- in_id  in  ID_WIDTH  original ID to map.
- grant_valid  out  1  registered one-cycle pulse after an allocate fire.
- grant_idx  out  IDX_W  slot granted (registered).
- grant_hit  out  1  1 = existing slot reused, 0 = new slot opened (registered).
- free_valid  in  1  one transaction retired on free_idx; always accepted.
- free_idx  in  IDX_W  slot being retired.
- lookup_idx  in  IDX_W  slot to look up.
- lookup_id  out  ID_WIDTH  combinational: stored ID of lookup_idx.
- used_slots  out  IDX_W+1  registered count of allocated slots.
- full  out  1  combinational: no unallocated slot.
- err  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Per-slot state: alloc bit, id[ID_WIDTH], cnt[CNT_WIDTH]. Reset (sync, rst=1): all alloc=0, id=0, cnt=0.
- Output reset values: grant_valid=0, grant_idx=0, grant_hit=0, used_slots=0, err=0.
- rst overrides any in-flight request: no grant is issued for a fire coincident with rst.
- Search (combinational, on registered state only):
  - hit = some slot with alloc=1 and id==in_id (at most one exists by construction).
  - first_free = lowest index with alloc=0.
- alloc_ready:
  - On hit: 1 iff the hit slot's cnt < 2^CNT_WIDTH-1. A saturated hit stalls; a second slot is never opened for the same ID.
  - On no hit: 1 iff !full.
  - alloc_ready does not depend on alloc_valid.
- Fire = alloc_valid & alloc_ready:
  - Hit: cnt+1.
  - Miss: alloc=1, id=in_id, cnt=1.
  - Next cycle: grant_valid=1, grant_idx=chosen slot, grant_hit=hit. Latency 1 cycle.
- Free (free_valid): cnt-1 on free_idx. When cnt goes 1->0, alloc=0 next cycle; id is retained until overwritten.
- Simultaneous alloc fire and free:
  - Different slots: both apply.
  - Same slot (hit): cnt unchanged. The slot stays allocated even if cnt was 1.
  - A slot freed this cycle is not visible to first_free until the next cycle (no combinational bypass).
- Free on a slot with alloc=0 or cnt=0: state unchanged (no underflow).
- used_slots tracks the alloc bits: +1 on miss fire, -1 on release, net 0 when both happen in the same cycle.
- full = (used allocated slots == MAX_OUTSTANDING); derived from alloc bits.
- in_id must be held stable while alloc_valid=1 and alloc_ready=0.

Optional Feature:
- Macro: ID_REMAP_TABLE_ERR_EN.
- Defined: err sets (sticky until rst) on any of:
  - free_valid to a slot with alloc=0;
  - free_idx >= MAX_OUTSTANDING;
  - alloc_valid dropping, or in_id changing, while stalled.
- Defined: sim-only assertions fire on the same conditions.
- Undefined: err tied to 0, no checking logic, table behaviour identical.

Test Plan:
- Reset, then alloc in_id=3 -> alloc_ready=1; next cycle grant_valid=1, grant_idx=0, grant_hit=0; used_slots=1.
- Alloc ID 3 twice more, then ID 5 -> ID 3 grants idx 0 with grant_hit=1 (cnt=3); ID 5 gets idx 1, grant_hit=0; lookup_idx=1 -> lookup_id=5.
- Fill 16 distinct IDs -> full=1, used_slots=16. Alloc a new ID 17th -> alloc_ready=0. Free idx 7 (cnt 1) -> next cycle full=0; stalled request fires, grant_idx=7.
- Alloc ID 2 fifteen times with CNT_WIDTH=4 -> the 16th is held with alloc_ready=0. One free on that slot -> request fires, grant_hit=1.
- Same cycle: free idx 0 (cnt=1) and alloc hit on ID at idx 0 -> slot stays allocated, cnt=1, used_slots unchanged. Assert rst mid-stall -> all outputs 0 next cycle, no grant issued.
- With ID_REMAP_TABLE_ERR_EN: free idx 4 while unallocated -> err=1 next cycle and stays 1 until rst. Without the macro -> err=0 throughout.
